// File: rtl/nvdla_cacc_sched_pkg.sv
// ----------------------------------------------------------------------------
// nvdla_cacc_sched_pkg
// Shared types for the CACC ping-pong register-group scheduler:
//   - cacc_state_e : scheduler FSM states (IDLE/START/BUSY/DONE)
//   - CACC_GRP_*   : per-group status encodings read back by software
//   - grp_onehot   : group index -> one-hot 2-bit mask
//   - grp_status   : status decode for one group
// ----------------------------------------------------------------------------
package nvdla_cacc_sched_pkg;

  typedef enum logic [1:0] {
    CACC_ST_IDLE  = 2'd0,
    CACC_ST_START = 2'd1,
    CACC_ST_BUSY  = 2'd2,
    CACC_ST_DONE  = 2'd3
  } cacc_state_e;

  localparam logic [1:0] CACC_GRP_IDLE    = 2'd0;
  localparam logic [1:0] CACC_GRP_RUNNING = 2'd1;
  localparam logic [1:0] CACC_GRP_PENDING = 2'd2;

  // One-hot mask selecting group g out of the two register groups.
  function automatic logic [1:0] grp_onehot(input logic g);
    logic [1:0] mask;
    if (g) begin
      mask = 2'b10;
    end else begin
      mask = 2'b01;
    end
    return mask;
  endfunction

  // RUNNING wins over PENDING: the executing group is still armed until DONE.
  function automatic logic [1:0] grp_status(input logic running, input logic armed);
    logic [1:0] st;
    if (running) begin
      st = CACC_GRP_RUNNING;
    end else if (armed) begin
      st = CACC_GRP_PENDING;
    end else begin
      st = CACC_GRP_IDLE;
    end
    return st;
  endfunction

endpackage

// File: rtl/nvdla_cacc_group_sched_if.sv
// ----------------------------------------------------------------------------
// nvdla_cacc_group_sched_if
// Bundles the software/datapath-facing signals of the group scheduler.
//   master : software + datapath side (drives producer/op_en_set/dp_done)
//   slave  : the scheduler itself
// Signals:
//   producer, op_en_set          software arm request for group `producer`
//   dp_done                      datapath layer-finished pulse
//   consumer, status_0/1, op_en  register-block readback fields
//   dp_start, dp_group           layer start to the datapath
//   done_intr, op_en_err,
//   timeout_err, layer_cnt       completion / error reporting
// ----------------------------------------------------------------------------
interface nvdla_cacc_group_sched_if #(
  parameter int CNT_W = 16
) ();

  logic             producer;
  logic             op_en_set;
  logic             dp_done;
  logic             consumer;
  logic [1:0]       status_0;
  logic [1:0]       status_1;
  logic [1:0]       op_en;
  logic             dp_start;
  logic             dp_group;
  logic [1:0]       done_intr;
  logic             op_en_err;
  logic             timeout_err;
  logic [CNT_W-1:0] layer_cnt;

  modport master (
    output producer,
    output op_en_set,
    output dp_done,
    input  consumer,
    input  status_0,
    input  status_1,
    input  op_en,
    input  dp_start,
    input  dp_group,
    input  done_intr,
    input  op_en_err,
    input  timeout_err,
    input  layer_cnt
  );

  modport slave (
    input  producer,
    input  op_en_set,
    input  dp_done,
    output consumer,
    output status_0,
    output status_1,
    output op_en,
    output dp_start,
    output dp_group,
    output done_intr,
    output op_en_err,
    output timeout_err,
    output layer_cnt
  );

endinterface

// File: rtl/nvdla_cacc_sched_wdog.sv
// ----------------------------------------------------------------------------
// nvdla_cacc_sched_wdog
// Busy-cycle watchdog. Counts cycles while i_en is high, clears on i_clr,
// and raises o_expire on the last allowed busy cycle (count == TIMEOUT-1).
// A TIMEOUT of zero disables expiry entirely.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : clear the counter (end of layer)
//   i_en         : count enable (FSM in BUSY)
//   o_expire     : high while enabled on the final permitted busy cycle
// ----------------------------------------------------------------------------
module nvdla_cacc_sched_wdog #(
  parameter int                   TIMEOUT_W = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 20'hF_FFFF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [TIMEOUT_W-1:0] LP_LAST  = TIMEOUT - TIMEOUT_W'(1);
  localparam logic                 LP_ARMED = (TIMEOUT != '0);

  logic [TIMEOUT_W-1:0] r_cnt;

  // Busy-cycle counter: clear has priority, otherwise count while enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TIMEOUT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Compare is against a registered count, so no input-to-output path exists
  // beyond the FSM-derived enable.
  assign o_expire = LP_ARMED & i_en & (r_cnt == LP_LAST);

endmodule

// File: rtl/nvdla_cacc_group_sched.sv
// ----------------------------------------------------------------------------
// nvdla_cacc_group_sched
// Ping-pong register-group scheduler for the CACC pipe. Software arms one of
// two register groups; this block executes armed groups in strict
// alternation, starts the datapath, retires the group on completion (or on
// watchdog abort) and reports status/completion back to software.
// Ports:
//   nvdla_core_clk : core clock
//   nvdla_core_rst : synchronous active-high reset
//   bus (slave)    : producer/op_en_set/dp_done in; consumer, status_0/1,
//                    op_en, dp_start, dp_group, done_intr, op_en_err,
//                    timeout_err, layer_cnt out
// ----------------------------------------------------------------------------
module nvdla_cacc_group_sched
  import nvdla_cacc_sched_pkg::*;
#(
  parameter int                   TIMEOUT_W = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 20'hF_FFFF,
  parameter int                   CNT_W     = 16
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rst,
  nvdla_cacc_group_sched_if.slave bus
);

  cacc_state_e      r_state;
  logic             r_consumer;
  logic [1:0]       r_op_en;
  logic             r_dp_start;
  logic [1:0]       r_done_intr;
  logic             r_op_en_err;
  logic             r_timeout_err;
  logic             r_abort;
  logic [CNT_W-1:0] r_layer_cnt;

  logic [1:0]       w_set_mask;
  logic [1:0]       w_clr_mask;
  logic [1:0]       w_op_en_nxt;
  logic             w_err_nxt;
  logic             w_busy;
  logic             w_done;
  logic             w_expire;

  assign w_busy = (r_state == CACC_ST_BUSY);
  assign w_done = (r_state == CACC_ST_DONE);

  nvdla_cacc_sched_wdog #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_wdog (
    .i_clk    (nvdla_core_clk),
    .i_rst    (nvdla_core_rst),
    .i_clr    (w_done),
    .i_en     (w_busy),
    .o_expire (w_expire)
  );

  // Arm request is judged against the current armed flags: a group that is
  // pending or running (including the DONE cycle that clears it) rejects it.
  assign w_err_nxt   = bus.op_en_set & r_op_en[bus.producer];
  assign w_set_mask  = (bus.op_en_set & ~r_op_en[bus.producer]) ?
                       grp_onehot(bus.producer) : 2'b00;
  assign w_clr_mask  = w_done ? grp_onehot(r_consumer) : 2'b00;
  assign w_op_en_nxt = (r_op_en | w_set_mask) & ~w_clr_mask;

  // Armed flags and the rejected-arm error pulse.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_op_en     <= 2'b00;
      r_op_en_err <= 1'b0;
    end else begin
      r_op_en     <= w_op_en_nxt;
      r_op_en_err <= w_err_nxt;
    end
  end

  // Scheduler FSM with its registered pulses, consumer pointer and counter.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state       <= CACC_ST_IDLE;
      r_consumer    <= 1'b0;
      r_dp_start    <= 1'b0;
      r_done_intr   <= 2'b00;
      r_timeout_err <= 1'b0;
      r_abort       <= 1'b0;
      r_layer_cnt   <= '0;
    end else begin
      r_dp_start    <= 1'b0;
      r_done_intr   <= 2'b00;
      r_timeout_err <= 1'b0;
      case (r_state)
        CACC_ST_IDLE: begin
          // Strict alternation: only the consumer group may start.
          if (r_op_en[r_consumer]) begin
            r_state    <= CACC_ST_START;
            r_dp_start <= 1'b1;
          end else begin
            r_state    <= CACC_ST_IDLE;
          end
        end
        CACC_ST_START: begin
          r_state <= CACC_ST_BUSY;
        end
        CACC_ST_BUSY: begin
          // Completion beats a same-cycle watchdog expiry.
          if (bus.dp_done) begin
            r_state <= CACC_ST_DONE;
            r_abort <= 1'b0;
          end else if (w_expire) begin
            r_state <= CACC_ST_DONE;
            r_abort <= 1'b1;
          end else begin
            r_state <= CACC_ST_BUSY;
          end
        end
        CACC_ST_DONE: begin
          if (r_abort) begin
            r_timeout_err <= 1'b1;
          end else begin
            r_done_intr <= grp_onehot(r_consumer);
            r_layer_cnt <= r_layer_cnt + CNT_W'(1);
          end
          r_abort    <= 1'b0;
          r_consumer <= ~r_consumer;
          r_state    <= CACC_ST_IDLE;
        end
        default: begin
          r_state <= CACC_ST_IDLE;
        end
      endcase
    end
  end

  assign bus.consumer    = r_consumer;
  assign bus.op_en       = r_op_en;
  assign bus.dp_start    = r_dp_start;
  assign bus.dp_group    = r_consumer;
  assign bus.done_intr   = r_done_intr;
  assign bus.op_en_err   = r_op_en_err;
  assign bus.timeout_err = r_timeout_err;
  assign bus.layer_cnt   = r_layer_cnt;

  // Status is decoded purely from registered state.
  assign bus.status_0 = grp_status((r_consumer == 1'b0) && (r_state != CACC_ST_IDLE),
                                   r_op_en[0]);
  assign bus.status_1 = grp_status((r_consumer == 1'b1) && (r_state != CACC_ST_IDLE),
                                   r_op_en[1]);

endmodule

// File: tb/tb_nvdla_cacc_group_sched.sv
// ----------------------------------------------------------------------------
// tb_nvdla_cacc_group_sched
// Directed bench for the CACC group scheduler (TIMEOUT=8, CNT_W=4).
// Inputs change on the falling edge; outputs are checked on the falling edge.
// ----------------------------------------------------------------------------
module tb_nvdla_cacc_group_sched;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  nvdla_cacc_group_sched_if #(.CNT_W(4)) bus ();

  nvdla_cacc_group_sched #(
    .TIMEOUT_W (20),
    .TIMEOUT   (20'd8),
    .CNT_W     (4)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arm group g, let it start, complete it, check the completion pulse.
  task automatic run_layer(input logic g);
    logic seen;
    bus.producer  = g;
    bus.op_en_set = 1'b1;
    step();
    bus.op_en_set = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      step();
      if (bus.dp_start === 1'b1) seen = 1'b1;
    end
    chk("w_start_seen", 32'(seen), 32'd1);
    chk("w_dp_group", 32'(bus.dp_group), 32'(g));
    step();
    bus.dp_done = 1'b1;
    step();
    bus.dp_done = 1'b0;
    step();
    chk("w_done_intr", 32'(bus.done_intr), g ? 32'd2 : 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.producer  = 1'b0;
    bus.op_en_set = 1'b0;
    bus.dp_done   = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_consumer", 32'(bus.consumer), 32'd0);
    chk("rst_status_0", 32'(bus.status_0), 32'd0);
    chk("rst_status_1", 32'(bus.status_1), 32'd0);
    chk("rst_op_en", 32'(bus.op_en), 32'd0);
    chk("rst_dp_start", 32'(bus.dp_start), 32'd0);
    chk("rst_done_intr", 32'(bus.done_intr), 32'd0);
    chk("rst_op_en_err", 32'(bus.op_en_err), 32'd0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    chk("rst_layer_cnt", 32'(bus.layer_cnt), 32'd0);

    // Single layer on group 0
    bus.producer  = 1'b0;
    bus.op_en_set = 1'b1;
    step();
    bus.op_en_set = 1'b0;
    chk("a_op_en", 32'(bus.op_en), 32'd1);
    chk("a_st0_pend", 32'(bus.status_0), 32'd2);
    chk("a_start_early", 32'(bus.dp_start), 32'd0);
    step();
    chk("a_dp_start", 32'(bus.dp_start), 32'd1);
    chk("a_dp_group", 32'(bus.dp_group), 32'd0);
    chk("a_st0_run", 32'(bus.status_0), 32'd1);
    step();
    chk("a_start_once", 32'(bus.dp_start), 32'd0);
    chk("a_st0_busy", 32'(bus.status_0), 32'd1);
    bus.dp_done = 1'b1;
    step();
    bus.dp_done = 1'b0;
    chk("a_done_wait", 32'(bus.done_intr), 32'd0);
    step();
    chk("a_done_intr", 32'(bus.done_intr), 32'd1);
    chk("a_consumer", 32'(bus.consumer), 32'd1);
    chk("a_layer_cnt", 32'(bus.layer_cnt), 32'd1);
    chk("a_st0_idle", 32'(bus.status_0), 32'd0);
    chk("a_op_en_clr", 32'(bus.op_en), 32'd0);
    step();
    chk("a_intr_pulse", 32'(bus.done_intr), 32'd0);

    // Group 0 armed while consumer is 1: must wait
    bus.producer  = 1'b0;
    bus.op_en_set = 1'b1;
    step();
    bus.op_en_set = 1'b0;
    chk("b_op_en0", 32'(bus.op_en), 32'd1);
    chk("b_st0_pend", 32'(bus.status_0), 32'd2);
    step();
    chk("b_alternate", 32'(bus.dp_start), 32'd0);
    chk("b_st0_still", 32'(bus.status_0), 32'd2);
    // Second arm of a pending group is rejected
    bus.op_en_set = 1'b1;
    step();
    bus.op_en_set = 1'b0;
    chk("b_dbl_err", 32'(bus.op_en_err), 32'd1);
    chk("b_dbl_op_en", 32'(bus.op_en), 32'd1);
    step();
    chk("b_err_pulse", 32'(bus.op_en_err), 32'd0);
    // Arm group 1 and run it
    bus.producer  = 1'b1;
    bus.op_en_set = 1'b1;
    step();
    bus.op_en_set = 1'b0;
    chk("b_op_en11", 32'(bus.op_en), 32'd3);
    chk("b_st1_pend", 32'(bus.status_1), 32'd2);
    step();
    chk("b_dp_start1", 32'(bus.dp_start), 32'd1);
    chk("b_dp_group1", 32'(bus.dp_group), 32'd1);
    chk("b_st1_run", 32'(bus.status_1), 32'd1);
    chk("b_st0_pend2", 32'(bus.status_0), 32'd2);
    step();
    bus.dp_done = 1'b1;
    step();
    bus.dp_done = 1'b0;
    // DONE cycle of group 1: re-arm of group 1 collides with its clear
    bus.producer  = 1'b1;
    bus.op_en_set = 1'b1;
    step();
    bus.op_en_set = 1'b0;
    chk("b_done_err", 32'(bus.op_en_err), 32'd1);
    chk("b_done_op_en", 32'(bus.op_en), 32'd1);
    chk("b_done_intr", 32'(bus.done_intr), 32'd2);
    chk("b_consumer", 32'(bus.consumer), 32'd0);
    chk("b_layer_cnt", 32'(bus.layer_cnt), 32'd2);
    chk("b_st1_idle", 32'(bus.status_1), 32'd0);
    step();
    chk("b_turnaround", 32'(bus.dp_start), 32'd1);
    chk("b_dp_group0", 32'(bus.dp_group), 32'd0);
    chk("b_st0_run", 32'(bus.status_0), 32'd1);

    // Watchdog abort on group 0 (no dp_done)
    step();
    chk("c_busy_start", 32'(bus.dp_start), 32'd0);
    repeat (7) step();
    chk("c_busy_last", 32'(bus.status_0), 32'd1);
    chk("c_no_to_yet", 32'(bus.timeout_err), 32'd0);
    step();
    chk("c_done_to", 32'(bus.timeout_err), 32'd0);
    chk("c_done_run", 32'(bus.status_0), 32'd1);
    step();
    chk("c_timeout_err", 32'(bus.timeout_err), 32'd1);
    chk("c_no_intr", 32'(bus.done_intr), 32'd0);
    chk("c_layer_same", 32'(bus.layer_cnt), 32'd2);
    chk("c_consumer", 32'(bus.consumer), 32'd1);
    chk("c_op_en", 32'(bus.op_en), 32'd0);
    step();
    chk("c_to_pulse", 32'(bus.timeout_err), 32'd0);

    // dp_done in IDLE is ignored
    bus.dp_done = 1'b1;
    step();
    bus.dp_done = 1'b0;
    chk("d_idle_intr", 32'(bus.done_intr), 32'd0);
    chk("d_idle_layer", 32'(bus.layer_cnt), 32'd2);
    chk("d_idle_st1", 32'(bus.status_1), 32'd0);
    step();
    chk("d_idle_intr2", 32'(bus.done_intr), 32'd0);
    chk("d_idle_cons", 32'(bus.consumer), 32'd1);

    // Reset during BUSY abandons the layer
    bus.producer  = 1'b1;
    bus.op_en_set = 1'b1;
    step();
    bus.op_en_set = 1'b0;
    step();
    chk("e_dp_start", 32'(bus.dp_start), 32'd1);
    step();
    chk("e_busy_st1", 32'(bus.status_1), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("e_consumer", 32'(bus.consumer), 32'd0);
    chk("e_op_en", 32'(bus.op_en), 32'd0);
    chk("e_status_0", 32'(bus.status_0), 32'd0);
    chk("e_status_1", 32'(bus.status_1), 32'd0);
    chk("e_layer_cnt", 32'(bus.layer_cnt), 32'd0);
    chk("e_dp_start0", 32'(bus.dp_start), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("e_no_intr", 32'(bus.done_intr), 32'd0);
      chk("e_no_to", 32'(bus.timeout_err), 32'd0);
    end

    // 16 completions wrap the 4-bit layer counter
    for (int i = 0; i < 16; i++) begin
      run_layer(i[0]);
      if (i == 14) chk("f_layer_15", 32'(bus.layer_cnt), 32'd15);
    end
    chk("f_layer_wrap", 32'(bus.layer_cnt), 32'd0);
    chk("f_consumer", 32'(bus.consumer), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
